// File: rtl/serial_mult_pkg.sv
// +--------------------------------------------------------------------------+
// | Module      : serial_mult_pkg                                            |
// | Description : Shared definitions for the serial Booth multiplier stream:|
// |               control FSM state encoding, product width derivation and  |
// |               a constant-foldable ceil(log2) helper.                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

package serial_mult_pkg;

  // Control FSM: collect operand bits, run Booth steps, hand result to FIFO.
  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_MULT = 2'd1,
    ST_PUSH = 2'd2
  } state_t;

  // A full product of two DATA_WIDTH-bit operands needs twice the width.
  function automatic int prod_width(input int data_width);
    return 2 * data_width;
  endfunction

  // Smallest bit count able to index 'value' entries (minimum 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end
    end
    if (r == 0) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_mult_fifo.sv
// +--------------------------------------------------------------------------+
// | Module      : serial_mult_fifo                                           |
// | Description : Synchronous result FIFO with full/empty flags. A push is   |
// |               honoured while full when a pop happens in the same cycle.  |
// |               Read data is show-ahead (head entry always on o_rdata).    |
// | Ports       : i_clk, i_rst (async, active-low), i_push/i_wdata,          |
// |               i_pop/o_rdata, o_full, o_empty                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module serial_mult_fifo
  import serial_mult_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int c_aw = clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [c_aw:0]    r_wr_ptr;
  logic [c_aw:0]    r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                     (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_rdata   = r_mem[r_rd_ptr[c_aw-1:0]];

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Storage needs no reset: entries are only observed after being written.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[c_aw-1:0]] <= i_wdata;
    end
  end

endmodule

`default_nettype wire

// File: rtl/serial_mult_stream.sv
// +--------------------------------------------------------------------------+
// | Module      : serial_mult_stream                                         |
// | Description : Bit-serial streaming multiplier. Operand bits arrive LSB   |
// |               first, a radix-2 Booth engine forms the exact product one  |
// |               multiplier bit per enabled cycle, results queue in a FIFO  |
// |               and leave LSB first, 2*DATA_WIDTH bits per word.           |
// | Ports       : i_clk, i_rst (async, active-low), i_en (global enable),    |
// |               i_din_a/i_din_b/i_valid/o_ready (serial operand input),    |
// |               o_prod/o_valid/i_ready (serial product output),            |
// |               i_acc_clr (only with SERIAL_MULT_ACCUM_EN defined).        |
// | Options     : SERIAL_MULT_ACCUM_EN - running accumulation of products,   |
// |               cleared by i_acc_clr sampled with operand bit 0.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module serial_mult_stream
  import serial_mult_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int SIGNED     = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_din_a,
  input  logic i_din_b,
  input  logic i_valid,
  output logic o_ready,
  output logic o_prod,
  output logic o_valid,
`ifdef SERIAL_MULT_ACCUM_EN
  input  logic i_acc_clr,
`endif
  input  logic i_ready
);

  localparam int c_prod_width = prod_width(DATA_WIDTH);
  // Unsigned operands get one zero bit so Booth sees them as non-negative.
  localparam int c_w          = (SIGNED != 0) ? DATA_WIDTH : DATA_WIDTH + 1;
  localparam int c_bit_w      = clog2(DATA_WIDTH);
  localparam int c_step_w     = clog2(c_w);
  localparam int c_ocnt_w     = clog2(c_prod_width);
  localparam logic [c_bit_w-1:0]  c_last_bit  = c_bit_w'(DATA_WIDTH - 1);
  localparam logic [c_step_w-1:0] c_last_step = c_step_w'(c_w - 1);
  localparam logic [c_ocnt_w-1:0] c_last_obit = c_ocnt_w'(c_prod_width - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;

  // Operand collection
  logic [c_bit_w-1:0]      r_bit;
  logic [DATA_WIDTH-2:0]   r_a_sh;
  logic [DATA_WIDTH-2:0]   r_b_sh;
  logic [DATA_WIDTH-1:0]   w_a_full;
  logic [DATA_WIDTH-1:0]   w_b_full;
  logic                    w_accept;
  logic                    w_last_in;

  // Booth engine: r_hi is one bit wider than the operands so that
  // subtracting the most negative multiplicand cannot overflow.
  logic [c_w:0]            w_mcand_ext;
  logic [c_w-1:0]          w_mplier_ext;
  logic [c_w:0]            r_mcand;
  logic [c_w:0]            r_hi;
  logic [c_w-1:0]          r_q;
  logic                    r_qm1;
  logic [c_step_w-1:0]     r_step;
  logic [c_w:0]            w_sum;
  logic [2*c_w:0]          w_next_full;
  logic                    w_mult_step;
  logic                    w_mult_done;

  // FIFO and output serializer
  logic                    w_push;
  logic                    w_pop;
  logic                    w_fifo_full;
  logic                    w_fifo_empty;
  logic [c_prod_width-1:0] w_fifo_wdata;
  logic [c_prod_width-1:0] w_fifo_rdata;
  logic                    r_busy;
  logic [c_prod_width-1:0] r_shift;
  logic [c_ocnt_w-1:0]     r_ocnt;
  logic                    w_obit_last;

  assign o_ready     = (r_state == ST_LOAD) & i_rst;
  assign w_accept    = i_en & i_valid & o_ready;
  assign w_last_in   = (r_bit == c_last_bit);
  assign w_mult_step = i_en & (r_state == ST_MULT);
  assign w_mult_done = w_mult_step & (r_step == c_last_step);
  assign w_push      = i_en & (r_state == ST_PUSH) & (~w_fifo_full | w_pop);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LOAD: if (w_accept && w_last_in) w_state_nxt = ST_MULT;
      ST_MULT: if (w_mult_done)           w_state_nxt = ST_PUSH;
      ST_PUSH: if (w_push)                w_state_nxt = ST_LOAD;
      default:                            w_state_nxt = ST_LOAD;
    endcase
  end

  // ------------------------------------------------------ operand intake
  // Bits shift in from the top so the first (LSB) bit ends at position 0.
  assign w_a_full = {i_din_a, r_a_sh};
  assign w_b_full = {i_din_b, r_b_sh};

  if (SIGNED != 0) begin : g_signed
    assign w_mcand_ext  = {w_a_full[DATA_WIDTH-1], w_a_full};
    assign w_mplier_ext = w_b_full;
  end else begin : g_unsigned
    assign w_mcand_ext  = {2'b00, w_a_full};
    assign w_mplier_ext = {1'b0, w_b_full};
  end

  // ------------------------------------------------------- Booth step
  always_comb begin
    w_sum = r_hi;
    case ({r_q[0], r_qm1})
      2'b01:   w_sum = r_hi + r_mcand;
      2'b10:   w_sum = r_hi - r_mcand;
      default: w_sum = r_hi;
    endcase
  end

  // {hi, q} after the arithmetic right shift of {sum, q, q_-1}.
  assign w_next_full = {w_sum[c_w], w_sum, r_q[c_w-1:1]};

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_bit   <= '0;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_mcand <= '0;
      r_hi    <= '0;
      r_q     <= '0;
      r_qm1   <= 1'b0;
      r_step  <= '0;
    end else begin
      if (w_accept) begin
        r_a_sh <= w_a_full[DATA_WIDTH-1:1];
        r_b_sh <= w_b_full[DATA_WIDTH-1:1];
        if (w_last_in) begin
          r_bit   <= '0;
          r_mcand <= w_mcand_ext;
          r_q     <= w_mplier_ext;
          r_hi    <= '0;
          r_qm1   <= 1'b0;
          r_step  <= '0;
        end else begin
          r_bit <= r_bit + 1'b1;
        end
      end
      if (w_mult_step) begin
        r_hi   <= w_next_full[2*c_w:c_w];
        r_q    <= w_next_full[c_w-1:0];
        r_qm1  <= r_q[0];
        r_step <= r_step + 1'b1;
      end
    end
  end

  // ------------------------------------------------------ result select
`ifdef SERIAL_MULT_ACCUM_EN
  logic                    r_clr;
  logic [c_prod_width-1:0] r_acc;

  // The accumulator takes the new sum on the final Booth step, so it already
  // holds the word to be pushed while the FSM sits in PUSH.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_clr <= 1'b0;
      r_acc <= '0;
    end else begin
      if (w_accept && (r_bit == '0)) begin
        r_clr <= i_acc_clr;
      end
      if (w_mult_done) begin
        r_acc <= (r_clr ? '0 : r_acc) + w_next_full[c_prod_width-1:0];
      end
    end
  end

  assign w_fifo_wdata = r_acc;
`else
  logic [2*c_w:0]              w_full_prod;
  logic [2*c_w-c_prod_width:0] w_unused_prod_msbs;

  // Upper bits only repeat the sign; the exact product fits the low half.
  assign w_full_prod        = {r_hi, r_q};
  assign w_fifo_wdata       = w_full_prod[c_prod_width-1:0];
  assign w_unused_prod_msbs = w_full_prod[2*c_w:c_prod_width];
`endif

  // --------------------------------------------------------------- FIFO
  serial_mult_fifo #(
    .WIDTH (c_prod_width),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_wdata (w_fifo_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // --------------------------------------------------------- serializer
  assign w_obit_last = (r_ocnt == c_last_obit);
  // Reload straight after the last bit so back-to-back words have no gap.
  assign w_pop   = i_en & ~w_fifo_empty & (~r_busy | (i_ready & w_obit_last));
  assign o_prod  = r_shift[0];
  assign o_valid = r_busy;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_busy  <= 1'b0;
      r_shift <= '0;
      r_ocnt  <= '0;
    end else begin
      if (w_pop) begin
        r_busy  <= 1'b1;
        r_shift <= w_fifo_rdata;
        r_ocnt  <= '0;
      end else if (i_en && r_busy && i_ready) begin
        if (w_obit_last) begin
          r_busy <= 1'b0;
        end else begin
          r_shift <= {1'b0, r_shift[c_prod_width-1:1]};
          r_ocnt  <= r_ocnt + 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire
